serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 18 +
 rtl/bit_timer.sv | 44 ++++
 rtl/serial_tx.sv | 153 +++++++++++++++
 tb/tb_serial_tx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter: FSM state encoding and
// frame-size helper.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   // Serial bits per frame: start + data + optional parity + stop.
   function automatic int FRAME_BITS(input int data_w, input int parity_en);
      return 32'sd2 + data_w + ((parity_en != 32'sd0) ? 32'sd1 : 32'sd0);
   endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1, flags the last cycle of
// each bit and exposes that flag for the following cycle.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic bit_end,
   output logic end_next
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_s;

   // Next count: clear restarts a new state at zero, otherwise wrap at LAST.
   always_comb begin
      cnt_s = cnt_r;
      if (clr) begin
         cnt_s = '0;
      end else if (cnt_r == LAST) begin
         cnt_s = '0;
      end else begin
         cnt_s = cnt_r + ONE;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_s;
      end
   end

   assign bit_end  = (cnt_r == LAST);
   assign end_next = (cnt_s == LAST);

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter with start/stop framing and optional even
// parity; every output is a flop loaded from next-state logic.
module serial_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_EN    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              sout,
   output logic              busy,
   output logic              done
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
   localparam logic [BW-1:0] ONE      = BW'(1);

   function automatic logic even_parity(input logic [DATA_W-1:0] v);
      return ^v;
   endfunction

   tx_state_e         state_r, state_s;
   logic [DATA_W-1:0] shift_r, shift_s;
   logic [BW-1:0]     bit_cnt_r, bit_cnt_s;
   logic              parity_r, parity_s;
   logic              sout_r, sout_s;
   logic              load_ready_r, load_ready_s;
   logic              busy_r, busy_s;
   logic              done_r, done_s;
   logic              bit_end_s, end_next_s, clr_s;

   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr_s),
      .bit_end  (bit_end_s),
      .end_next (end_next_s)
   );

   // Frame sequencing: state, shift register, bit counter and parity capture.
   always_comb begin
      state_s   = state_r;
      shift_s   = shift_r;
      bit_cnt_s = bit_cnt_r;
      parity_s  = parity_r;
      case (state_r)
         IDLE: begin
            if (load_valid && load_ready_r) begin
               state_s  = START;
               shift_s  = din;
               parity_s = even_parity(din);
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (bit_end_s) begin
               state_s = DATA;
            end else begin
               state_s = START;
            end
         end
         DATA: begin
            if (bit_end_s) begin
               shift_s = shift_r >> 1'b1;
               if (bit_cnt_r == LAST_BIT) begin
                  state_s = (PARITY_EN != 32'sd0) ? PARITY : STOP;
               end else begin
                  state_s   = DATA;
                  bit_cnt_s = bit_cnt_r + ONE;
               end
            end else begin
               state_s = DATA;
            end
         end
         PARITY: begin
            if (bit_end_s) begin
               state_s = STOP;
            end else begin
               state_s = PARITY;
            end
         end
         STOP: begin
            if (bit_end_s) begin
               state_s = IDLE;
            end else begin
               state_s = STOP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
      clr_s = (state_s != state_r);
      if (clr_s) begin
         bit_cnt_s = '0;
      end else begin
         bit_cnt_s = bit_cnt_s;
      end
   end

   // Output values for the next cycle, derived from the next state so the
   // flops present the line level with no extra latency.
   always_comb begin
      sout_s = 1'b1;
      case (state_s)
         IDLE:    sout_s = 1'b1;
         START:   sout_s = 1'b0;
         DATA:    sout_s = shift_s[0];
         PARITY:  sout_s = parity_s;
         STOP:    sout_s = 1'b1;
         default: sout_s = 1'b1;
      endcase
      load_ready_s = (state_s == IDLE);
      busy_s       = (state_s != IDLE);
      done_s       = (state_s == STOP) && end_next_s;
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         shift_r      <= '0;
         bit_cnt_r    <= '0;
         parity_r     <= 1'b0;
         sout_r       <= 1'b1;
         load_ready_r <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         state_r      <= state_s;
         shift_r      <= shift_s;
         bit_cnt_r    <= bit_cnt_s;
         parity_r     <= parity_s;
         sout_r       <= sout_s;
         load_ready_r <= load_ready_s;
         busy_r       <= busy_s;
         done_r       <= done_s;
      end
   end

   assign sout       = sout_r;
   assign load_ready = load_ready_r;
   assign busy       = busy_r;
   assign done       = done_r;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: a default instance (4 clocks/bit, parity)
// and a fast instance (1 clock/bit, no parity) against a frame-level model.
module tb_serial_tx;
   import serial_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] din_a = 8'h00;
   logic [7:0] din_b = 8'h00;
   logic       lv_a = 1'b0;
   logic       lv_b = 1'b0;
   logic       sout_a, ready_a, busy_a, done_a;
   logic       sout_b, ready_b, busy_b, done_b;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
      .clk(clk), .rst(rst), .din(din_a), .load_valid(lv_a),
      .load_ready(ready_a), .sout(sout_a), .busy(busy_a), .done(done_a)
   );

   serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
      .clk(clk), .rst(rst), .din(din_b), .load_valid(lv_b),
      .load_ready(ready_b), .sout(sout_b), .busy(busy_b), .done(done_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic [7:0] d, input logic v);
      if (sel) begin
         din_b = d;
         lv_b  = v;
      end else begin
         din_a = d;
         lv_a  = v;
      end
   endtask

   // Line level of serial bit idx in a frame: start, data LSB first, parity, stop.
   function automatic logic exp_bit(input logic [7:0] w, input int pen, input int idx);
      logic [7:0] t;
      if (idx == 0) return 1'b0;
      if (idx <= 8) begin
         t = w >> (idx - 1);
         return t[0];
      end
      if (pen != 0 && idx == 9) return ^w;
      return 1'b1;
   endfunction

   // Sends one word and checks every cycle of its frame plus the following idle cycle.
   // keep: hold load_valid with w_next for a back-to-back follow-up frame.
   // disturb: toggle din and pulse load_valid while the frame is in flight.
   task automatic run_frame(input bit sel, input logic [7:0] w, input bit keep,
                            input logic [7:0] w_next, input bit disturb);
      int cpb = sel ? 1 : 4;
      int pen = sel ? 0 : 1;
      int len = FRAME_BITS(8, pen) * cpb;
      check("ready_before_load", sel ? ready_b : ready_a, 1'b1);
      drive(sel, w, 1'b1);
      tick();
      for (int c = 1; c <= len; c++) begin
         if (keep) drive(sel, w_next, 1'b1);
         else if (disturb) drive(sel, 8'($urandom), 1'($urandom_range(0, 1)));
         else drive(sel, 8'($urandom), 1'b0);
         check($sformatf("sout w=%h cyc=%0d", w, c), sel ? sout_b : sout_a,
               exp_bit(w, pen, (c - 1) / cpb));
         check($sformatf("busy cyc=%0d", c), sel ? busy_b : busy_a, 1'b1);
         check($sformatf("ready cyc=%0d", c), sel ? ready_b : ready_a, 1'b0);
         check($sformatf("done cyc=%0d", c), sel ? done_b : done_a, c == len);
         tick();
      end
      if (!keep) drive(sel, 8'h00, 1'b0);
      check("ready_after_frame", sel ? ready_b : ready_a, 1'b1);
      check("busy_after_frame", sel ? busy_b : busy_a, 1'b0);
      check("done_after_frame", sel ? done_b : done_a, 1'b0);
      check("sout_after_frame", sel ? sout_b : sout_a, 1'b1);
   endtask

   initial begin
      logic [7:0] w1;
      logic [7:0] w2;

      // Reset values while rst is held.
      repeat (3) tick();
      check("rst_sout_a", sout_a, 1'b1);
      check("rst_ready_a", ready_a, 1'b0);
      check("rst_busy_a", busy_a, 1'b0);
      check("rst_done_a", done_a, 1'b0);
      check("rst_sout_b", sout_b, 1'b1);
      check("rst_ready_b", ready_b, 1'b0);
      check("rst_busy_b", busy_b, 1'b0);
      check("rst_done_b", done_b, 1'b0);
      rst = 1'b0;
      tick();
      check("ready_after_rst_a", ready_a, 1'b1);
      check("ready_after_rst_b", ready_b, 1'b1);

      // Directed frames: reference word, parity extremes.
      run_frame(1'b0, 8'hA5, 1'b0, 8'h00, 1'b0);
      run_frame(1'b0, 8'h01, 1'b0, 8'h00, 1'b0);
      run_frame(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);

      // Back-to-back with load_valid held: 45-cycle spacing.
      run_frame(1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
      run_frame(1'b0, 8'hFF, 1'b0, 8'h00, 1'b0);

      // Input activity during a frame must not change it or start another.
      run_frame(1'b0, 8'h96, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 6; i++) begin
         check("idle_busy_after_disturb", busy_a, 1'b0);
         check("idle_sout_after_disturb", sout_a, 1'b1);
         tick();
      end

      // Reset in cycle 20 of a frame aborts it with no done and no resumption.
      check("ready_before_abort", ready_a, 1'b1);
      drive(1'b0, 8'h5A, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         check($sformatf("sout_pre_abort cyc=%0d", c), sout_a, exp_bit(8'h5A, 1, (c - 1) / 4));
         if (c < 20) tick();
      end
      rst = 1'b1;
      tick();
      check("abort_sout", sout_a, 1'b1);
      check("abort_done", done_a, 1'b0);
      check("abort_busy", busy_a, 1'b0);
      check("abort_ready", ready_a, 1'b0);
      rst = 1'b0;
      tick();
      check("abort_ready_after_rst", ready_a, 1'b1);
      for (int i = 0; i < 48; i++) begin
         check("abort_no_done", done_a, 1'b0);
         check("abort_no_resume", busy_a, 1'b0);
         tick();
      end

      // Reset wins over a simultaneous load handshake.
      rst = 1'b1;
      drive(1'b0, 8'hC3, 1'b1);
      tick();
      rst = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("rst_vs_load_busy", busy_a, 1'b0);
         check("rst_vs_load_sout", sout_a, 1'b1);
         tick();
      end

      // One clock per bit, no parity.
      run_frame(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);

      // Randomized frames on both instances.
      for (int k = 0; k < 6; k++) begin
         run_frame(1'b0, 8'($urandom), 1'b0, 8'h00, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) tick();
      end
      for (int k = 0; k < 4; k++) begin
         w1 = 8'($urandom);
         w2 = 8'($urandom);
         run_frame(1'b1, w1, 1'b1, w2, 1'b0);
         run_frame(1'b1, w2, 1'b0, 8'h00, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
